fetch_queue_unit: RTL and testbench

- Parametrised instruction fetch stage for the pipeline front end.
- Issues sequential instruction-memory requests from an internal program counter.
- Buffers in-order responses, together with their PCs, in a DEPTH-entry prefetch queue.
- Presents them to decode through a valid/ready handshake; adds stall back-pressure, branch redirect with flush, and multi-outstanding memory requests.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/sync_fifo.sv | 78 +++++++
 rtl/fetch_queue_unit.sv | 134 +++++++++++++
 tb/tb_fetch_queue_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
// Holds the default address/instruction widths, the reset PC and the prefetch
// queue entry layout used by the fetch stage and its bench.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 8;
  localparam int unsigned FETCH_INSTR_W = 16;

  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

  // One prefetch queue entry: the instruction together with the PC it came from.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and no read bypass.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset (clears pointers and storage)
//   flush_i       : drop all entries at the next edge (wins over push/pop)
//   push_i/data_i : write side; a push while full is accepted only with a pop
//   pop_i/data_o  : read side; data_o is the head entry, pop ignored when empty
//   full_o, empty_o, count_o : occupancy
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      assert (!(push_i && full_o && !pop_i))
        else $error("sync_fifo: push into a full fifo");
    end
  end

endmodule : sync_fifo

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: issues sequential imem requests from fetch_pc,
// pairs in-order responses with their PCs and buffers them for decode.
// Ports:
//   clk_i, rst_ni          : clock, async active-low reset
//   imem_req_*             : request channel (valid/ready, addr = fetch PC)
//   imem_resp_*            : in-order responses, latency >= 1 cycle
//   redirect_valid_i/pc_i  : flush the queue and restart fetch at redirect_pc_i
//   out_valid_o/ready_i    : head handshake to decode; out_instr_o/out_pc_o = head
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
  parameter int unsigned       PC_STEP  = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               imem_req_valid_o,
  input  logic               imem_req_ready_i,
  output logic [ADDR_W-1:0]  imem_req_addr_o,
  input  logic               imem_resp_valid_i,
  input  logic [INSTR_W-1:0] imem_resp_data_i,
  input  logic               redirect_valid_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0]  out_pc_o
);

  localparam int unsigned     CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned     EntryW = ADDR_W + INSTR_W;
  localparam logic [CntW:0]   Credit = (CntW + 1)'(DEPTH);

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]    inflight_q, inflight_d;
  logic [CntW-1:0]    drop_q, drop_d;

  logic               req_fire;
  logic [CntW:0]      credit_used;
  logic               q_push, q_pop, q_empty, q_full;
  logic [CntW-1:0]    q_count;
  logic [EntryW-1:0]  q_wdata, q_rdata;
  logic [ADDR_W-1:0]  rsp_pc;
  logic               pcf_full, pcf_empty;
  logic [CntW-1:0]    pcf_count;
  logic               unused_status;

  // Buffered plus in-flight entries may never exceed DEPTH, so the queue cannot overflow.
  assign credit_used = {1'b0, q_count} + {1'b0, inflight_q};

  // rst_ni gates the request so it drops the moment reset asserts, not at the next edge.
  assign imem_req_valid_o = rst_ni && !redirect_valid_i && (credit_used < Credit);
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  // Responses owed to a pre-redirect PC stream are discarded while drop_q is non-zero.
  assign q_push  = imem_resp_valid_i && (drop_q == '0) && !redirect_valid_i;
  assign q_pop   = !q_empty && out_ready_i && !redirect_valid_i;
  assign q_wdata = {rsp_pc, imem_resp_data_i};

  assign out_valid_o             = !q_empty;
  assign {out_pc_o, out_instr_o} = q_rdata;

  assign unused_status = ^{q_full, pcf_full, pcf_empty, pcf_count};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid_i) begin
      fetch_pc_d = redirect_pc_i;
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
    end

    inflight_d = inflight_q + CntW'(req_fire) - CntW'(imem_resp_valid_i);

    drop_d = drop_q;
    if (redirect_valid_i) begin
      // Everything still unreturned after this cycle belongs to the old stream.
      drop_d = inflight_q - CntW'(imem_resp_valid_i);
    end else if (imem_resp_valid_i && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_valid_i),
    .push_i  (q_push),
    .data_i  (q_wdata),
    .pop_i   (q_pop),
    .data_o  (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  // Tracks the address of every issued request; never flushed, because the
  // dropped responses still have to consume their entries.
  sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .data_i  (fetch_pc_q),
    .pop_i   (imem_resp_valid_i),
    .data_o  (rsp_pc),
    .full_o  (pcf_full),
    .empty_o (pcf_empty),
    .count_o (pcf_count)
  );

endmodule : fetch_queue_unit

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: an in-order memory with per-request latency and a
// queue-level model of what decode should see (outstanding requests marked stale
// on redirect, a list of deliverable {pc, instr} entries, the next fetch PC).
module tb_fetch_queue_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [7:0]  req_addr;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        redir_valid;
  logic [7:0]  redir_pc;
  logic        out_valid, out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;

  logic        w_req_valid, w_resp_valid, w_out_valid;
  logic [7:0]  w_req_addr, w_out_pc;
  logic [15:0] w_resp_data, w_out_instr;

  fetch_queue_unit #(
    .ADDR_W(8), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(8'h00), .PC_STEP(1)
  ) u_dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .imem_req_valid_o  (req_valid),
    .imem_req_ready_i  (req_ready),
    .imem_req_addr_o   (req_addr),
    .imem_resp_valid_i (resp_valid),
    .imem_resp_data_i  (resp_data),
    .redirect_valid_i  (redir_valid),
    .redirect_pc_i     (redir_pc),
    .out_valid_o       (out_valid),
    .out_ready_i       (out_ready),
    .out_instr_o       (out_instr),
    .out_pc_o          (out_pc)
  );

  fetch_queue_unit #(
    .ADDR_W(8), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(8'hFE), .PC_STEP(1)
  ) u_dut_wrap (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .imem_req_valid_o  (w_req_valid),
    .imem_req_ready_i  (1'b1),
    .imem_req_addr_o   (w_req_addr),
    .imem_resp_valid_i (w_resp_valid),
    .imem_resp_data_i  (w_resp_data),
    .redirect_valid_i  (1'b0),
    .redirect_pc_i     (8'h00),
    .out_valid_o       (w_out_valid),
    .out_ready_i       (1'b1),
    .out_instr_o       (w_out_instr),
    .out_pc_o          (w_out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [7:0] pc; bit stale; } outst_t;
  typedef struct { logic [7:0] addr; int due; } memreq_t;

  int checks = 0;
  int errors = 0;

  outst_t       outst[$];
  fetch_entry_t mq[$];
  memreq_t      memq[$];
  logic [7:0]   m_pc;
  int           cyc, last_due, lat_min, lat_max, ready_pct, first_ov;
  int           fire_cyc[$];
  logic [7:0]   fire_addr[$];
  logic [7:0]   dl_pc[$];
  logic [15:0]  dl_instr[$];
  logic [7:0]   w_a[$];
  logic [7:0]   w_p[$];
  logic [7:0]   wrap_exp[4];
  bit           w_fired;
  logic [7:0]   w_addr;

  function automatic logic [15:0] img(input logic [7:0] a);
    return 16'hA000 + {8'h00, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Asserts reset between clock edges, checks the outputs fall at once, then
  // releases it just after a rising edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    redir_valid = 1'b0; out_ready = 1'b1; resp_valid = 1'b0; req_ready = 1'b0;
    w_resp_valid = 1'b0;
    #1;
    chk("rst_req_valid", 32'(req_valid), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_pc", 32'(out_pc), 32'(0));
    chk("rst_out_instr", 32'(out_instr), 32'(0));
    chk("rst_wrap_req_valid", 32'(w_req_valid), 32'(0));
    memq.delete(); outst.delete(); mq.delete();
    m_pc = 8'h00; last_due = -1; w_fired = 1'b0; w_addr = 8'h00;
    fire_cyc.delete(); fire_addr.delete(); dl_pc.delete(); dl_instr.delete();
    first_ov = -1;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick();
    outst_t  o;
    memreq_t m;
    bit      fire;
    int      due;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = img(memq[0].addr);
    end else begin
      resp_valid = 1'b0;
      resp_data  = 16'($urandom);
    end
    req_ready    = ($urandom_range(99) < ready_pct);
    w_resp_valid = w_fired;
    w_resp_data  = img(w_addr);
    #1;
    chk("req_valid", 32'(req_valid),
        32'(((mq.size() + outst.size()) < DEPTH) && !redir_valid));
    if (req_valid) chk("req_addr", 32'(req_addr), 32'(m_pc));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_pc", 32'(out_pc), 32'(mq[0].pc));
      chk("out_instr", 32'(out_instr), 32'(mq[0].instr));
    end
    if (w_out_valid) chk("wrap_instr", 32'(w_out_instr), 32'(img(w_out_pc)));

    if (out_valid && first_ov < 0) first_ov = cyc;
    if (out_valid && out_ready && !redir_valid) begin
      dl_pc.push_back(out_pc);
      dl_instr.push_back(out_instr);
    end
    fire = req_valid && req_ready;
    if (fire) begin
      fire_cyc.push_back(cyc);
      fire_addr.push_back(req_addr);
    end
    if (w_req_valid && w_a.size() < 4) w_a.push_back(w_req_addr);
    if (w_out_valid && w_p.size() < 4) w_p.push_back(w_out_pc);
    w_fired = w_req_valid;
    w_addr  = w_req_addr;

    // Model advance for the coming edge: head leaves, response joins the tail.
    if (mq.size() > 0 && out_ready && !redir_valid) void'(mq.pop_front());
    if (resp_valid) begin
      void'(memq.pop_front());
      if (outst.size() > 0) begin
        o = outst.pop_front();
        if (!o.stale && !redir_valid) mq.push_back('{pc: o.pc, instr: img(o.pc)});
      end
    end
    if (fire) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      m.addr = req_addr;
      m.due  = due;
      memq.push_back(m);
      o.pc    = m_pc;
      o.stale = 1'b0;
      outst.push_back(o);
      m_pc = m_pc + 8'd1;
    end
    if (redir_valid) begin
      mq.delete();
      foreach (outst[i]) outst[i].stale = 1'b1;
      m_pc = redir_pc;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; out_ready = 1'b1; redir_valid = 1'b0; redir_pc = 8'h00;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    w_resp_valid = 1'b0; w_resp_data = '0;
    ready_pct = 100; lat_min = 1; lat_max = 1; cyc = 0; first_ov = -1;
    wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    // Streaming with a 1-cycle memory.
    do_reset();
    repeat (20) tick();
    for (int i = 0; i < 8; i++) begin
      if (i < fire_cyc.size()) begin
        chk("stream_addr", 32'(fire_addr[i]), 32'(i));
        chk("stream_back_to_back", 32'(fire_cyc[i] - fire_cyc[0]), 32'(i));
      end else chk("stream_fire_count", 32'(fire_cyc.size()), 32'(8));
      if (i < dl_pc.size()) begin
        chk("stream_out_pc", 32'(dl_pc[i]), 32'(i));
        chk("stream_out_instr", 32'(dl_instr[i]), 32'(16'hA000 + i));
      end else chk("stream_deliver_count", 32'(dl_pc.size()), 32'(8));
    end
    if (fire_cyc.size() > 0) chk("stream_latency", 32'(first_ov - fire_cyc[0]), 32'(2));
    for (int i = 0; i < 4; i++) begin
      if (i < w_a.size()) chk("wrap_addr", 32'(w_a[i]), 32'(wrap_exp[i]));
      else chk("wrap_addr_count", 32'(w_a.size()), 32'(4));
      if (i < w_p.size()) chk("wrap_out_pc", 32'(w_p[i]), 32'(wrap_exp[i]));
      else chk("wrap_out_count", 32'(w_p.size()), 32'(4));
    end

    // Stall: decode holds off for 10 cycles.
    do_reset();
    out_ready = 1'b0;
    repeat (10) tick();
    chk("stall_fires", 32'(fire_cyc.size()), 32'(4));
    chk("stall_req_valid", 32'(req_valid), 32'(0));
    chk("stall_out_valid", 32'(out_valid), 32'(1));
    chk("stall_head_pc", 32'(out_pc), 32'(0));
    out_ready = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 6; i++) begin
      if (i < dl_pc.size()) chk("stall_drain_pc", 32'(dl_pc[i]), 32'(i));
      else chk("stall_drain_count", 32'(dl_pc.size()), 32'(6));
    end
    if (fire_addr.size() > 4) chk("stall_resume_addr", 32'(fire_addr[4]), 32'(4));
    else chk("stall_resume_count", 32'(fire_addr.size()), 32'(5));

    // Redirect with a 3-cycle memory and requests in flight.
    do_reset();
    lat_min = 3; lat_max = 3;
    repeat (10) tick();
    dl_pc.delete(); dl_instr.delete();
    redir_valid = 1'b1; redir_pc = 8'h40;
    tick();
    redir_valid = 1'b0;
    repeat (15) tick();
    if (dl_pc.size() > 0) begin
      chk("redir_first_pc", 32'(dl_pc[0]), 32'(8'h40));
      chk("redir_first_instr", 32'(dl_instr[0]), 32'(16'hA040));
    end else chk("redir_deliver_count", 32'(dl_pc.size()), 32'(1));
    foreach (dl_pc[i]) chk("redir_no_stale", 32'(dl_pc[i] >= 8'h40 && dl_pc[i] < 8'h50), 32'(1));

    // Back-to-back redirects.
    repeat (6) tick();
    dl_pc.delete(); dl_instr.delete();
    redir_valid = 1'b1; redir_pc = 8'h10;
    tick();
    redir_pc = 8'h20;
    tick();
    redir_valid = 1'b0;
    repeat (20) tick();
    if (dl_pc.size() > 0) chk("b2b_first_pc", 32'(dl_pc[0]), 32'(8'h20));
    else chk("b2b_deliver_count", 32'(dl_pc.size()), 32'(1));
    foreach (dl_pc[i]) chk("b2b_no_stale", 32'(dl_pc[i] >= 8'h20 && dl_pc[i] < 8'h30), 32'(1));

    // Asynchronous reset in the middle of a stream.
    lat_min = 1; lat_max = 1;
    repeat (8) tick();
    chk("pre_reset_out_valid", 32'(out_valid), 32'(1));
    do_reset();
    repeat (6) tick();
    if (fire_addr.size() > 0) chk("restart_addr", 32'(fire_addr[0]), 32'(0));
    else chk("restart_fire_count", 32'(fire_addr.size()), 32'(1));
    if (dl_pc.size() > 0) chk("restart_out_pc", 32'(dl_pc[0]), 32'(0));
    else chk("restart_deliver_count", 32'(dl_pc.size()), 32'(1));

    // Random traffic: back-pressure on both sides, mixed latency, redirects.
    lat_min = 1; lat_max = 4; ready_pct = 70;
    for (int n = 0; n < 400; n++) begin
      out_ready   = ($urandom_range(99) < 60);
      redir_valid = ($urandom_range(99) < 4);
      redir_pc    = 8'($urandom);
      tick();
    end
    redir_valid = 1'b0; out_ready = 1'b1; ready_pct = 100;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_queue_unit
